// File: rtl/ceespu_pkg.sv
// Shared ceespu encodings: ALU opcodes, carry-in/writeback/branch selects,
// multiplier state enum and the branch-condition helper.
package ceespu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_OR     = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_XOR    = 4'd3;
    localparam logic [3:0] ALU_SEXT8  = 4'd4;
    localparam logic [3:0] ALU_SEXT16 = 4'd5;
    localparam logic [3:0] ALU_SHL    = 4'd6;
    localparam logic [3:0] ALU_SHR    = 4'd7;
    localparam logic [3:0] ALU_SAR    = 4'd8;
    localparam logic [3:0] ALU_MUL    = 4'd9;

    localparam logic [1:0] CIN_ZERO   = 2'd0;
    localparam logic [1:0] CIN_CFLAG  = 2'd1;
    localparam logic [1:0] CIN_CFLAG2 = 2'd2;
    localparam logic [1:0] CIN_ONE    = 2'd3;

    localparam logic [1:0] WE_ALU  = 2'd0;
    localparam logic [1:0] WE_MEM  = 2'd1;
    localparam logic [1:0] WE_LINK = 2'd3;

    localparam logic [2:0] BR_ALWAYS  = 3'd0;
    localparam logic [2:0] BR_Z       = 3'd1;
    localparam logic [2:0] BR_NZ      = 3'd2;
    localparam logic [2:0] BR_C       = 3'd3;
    localparam logic [2:0] BR_NC      = 3'd4;
    localparam logic [2:0] BR_N       = 3'd5;
    localparam logic [2:0] BR_NN      = 3'd6;
    localparam logic [2:0] BR_ALWAYS2 = 3'd7;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // flags are packed {N,Z,C}
    function automatic logic branch_cond(input logic [2:0] op, input logic [2:0] flags);
        logic taken;
        case (op)
            BR_ALWAYS:  taken = 1'b1;
            BR_Z:       taken = flags[1];
            BR_NZ:      taken = ~flags[1];
            BR_C:       taken = flags[0];
            BR_NC:      taken = ~flags[0];
            BR_N:       taken = flags[2];
            BR_NN:      taken = ~flags[2];
            BR_ALWAYS2: taken = 1'b1;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ceespu_execute_if.sv
// Decode-to-execute bundle and execute result/branch/stall outputs.
interface ceespu_execute_if;
    logic [31:0] I_dataA;
    logic [31:0] I_dataB;
    logic [3:0]  I_aluop;
    logic [1:0]  I_selCin;
    logic        I_we;
    logic [4:0]  I_regD;
    logic [1:0]  I_selWe;
    logic [3:0]  I_selMem;
    logic        I_isBranch;
    logic [2:0]  I_branchOp;
    logic [13:0] I_branchAddress;
    logic [13:0] I_PC;

    logic [31:0] O_result;
    logic        O_we;
    logic [4:0]  O_regD;
    logic [1:0]  O_selWe;
    logic [3:0]  O_selMem;
    logic        O_branchTaken;
    logic [13:0] O_branchTarget;
    logic        O_flush;
    logic        O_stall;
    logic [2:0]  O_flags;

    modport master (
        output I_dataA, I_dataB, I_aluop, I_selCin, I_we, I_regD, I_selWe, I_selMem,
               I_isBranch, I_branchOp, I_branchAddress, I_PC,
        input  O_result, O_we, O_regD, O_selWe, O_selMem, O_branchTaken,
               O_branchTarget, O_flush, O_stall, O_flags
    );

    modport slave (
        input  I_dataA, I_dataB, I_aluop, I_selCin, I_we, I_regD, I_selWe, I_selMem,
               I_isBranch, I_branchOp, I_branchAddress, I_PC,
        output O_result, O_we, O_regD, O_selWe, O_selMem, O_branchTaken,
               O_branchTarget, O_flush, O_stall, O_flags
    );
endinterface

// File: rtl/ceespu_multiplier.sv
// Iterative 32x32 (low word) multiplier with start/busy/done handshake.
// Defining CEESPU_FAST_MUL_EN swaps in a single-cycle combinational multiply.
module ceespu_multiplier
    import ceespu_pkg::*;
#(
    parameter int STEP_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);
`ifdef CEESPU_FAST_MUL_EN
    assign busy_o    = 1'b0;
    assign done_o    = start_i;
    assign product_o = a_i * b_i;
`else
    localparam int STEPS = 32 / STEP_BITS;

    mul_state_e  state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] pp_s;

    // Partial product: whole A (pre-shifted) times the next STEP_BITS slice of B.
    always_comb begin
        pp_s = a_q * {{(32 - STEP_BITS){1'b0}}, b_q[STEP_BITS-1:0]};
    end

    // Next-state and datapath update for the multiply sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        count_d = count_q;
        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    state_d = MUL_BUSY;
                    a_d     = a_i;
                    b_d     = b_i;
                    acc_d   = 32'd0;
                    count_d = 3'd0;
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                acc_d   = acc_q + pp_s;
                a_d     = a_q << STEP_BITS;
                b_d     = b_q >> STEP_BITS;
                count_d = count_q + 3'd1;
                if (count_q == 3'(STEPS - 1)) begin
                    state_d = MUL_DONE;
                end else begin
                    state_d = MUL_BUSY;
                end
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 32'd0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    // Busy covers the accepting IDLE cycle too so upstream holds the MUL.
    assign busy_o    = ((state_q == MUL_IDLE) && start_i) || (state_q == MUL_BUSY);
    assign done_o    = (state_q == MUL_DONE);
    assign product_o = acc_q;
`endif
endmodule

// File: rtl/ceespu_execute.sv
// ceespu execute stage: ALU, Z/N/C flags, branch resolution, multiplier stall
// and the result register. CEESPU_FAST_MUL_EN selects the single-cycle multiplier.
module ceespu_execute
    import ceespu_pkg::*;
#(
    parameter int MUL_STEP_BITS = 8
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    ceespu_execute_if.slave  bus
);
    logic        cin_s;
    logic [32:0] sum_s;
    logic [31:0] alu_s, result_s, mul_product_s;
    logic [13:0] link_pc_s;
    logic        mul_start_s, mul_busy_s, mul_done_s, stall_s;

    logic [31:0] result_q, result_d;
    logic        we_q, we_d;
    logic [4:0]  regd_q, regd_d;
    logic [1:0]  selwe_q, selwe_d;
    logic [3:0]  selmem_q, selmem_d;
    logic [2:0]  flags_q, flags_d;

    assign mul_start_s = (bus.I_aluop == ALU_MUL) && bus.I_we;

    ceespu_multiplier #(.STEP_BITS(MUL_STEP_BITS)) u_mul (
        .clk       (I_clk),
        .rst_n     (I_rst_n),
        .start_i   (mul_start_s),
        .a_i       (bus.I_dataA),
        .b_i       (bus.I_dataB),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .product_o (mul_product_s)
    );

    assign stall_s = I_rst_n & mul_busy_s;

    // Carry-in select and the shared ADD/SUB adder.
    always_comb begin
        case (bus.I_selCin)
            CIN_ZERO:   cin_s = 1'b0;
            CIN_CFLAG:  cin_s = flags_q[0];
            CIN_CFLAG2: cin_s = flags_q[0];
            CIN_ONE:    cin_s = 1'b1;
            default:    cin_s = 1'b0;
        endcase
        sum_s = {1'b0, bus.I_dataA} + {1'b0, bus.I_dataB} + {32'd0, cin_s};
    end

    // ALU operation select.
    always_comb begin
        case (bus.I_aluop)
            ALU_ADD:    alu_s = sum_s[31:0];
            ALU_OR:     alu_s = bus.I_dataA | bus.I_dataB;
            ALU_AND:    alu_s = bus.I_dataA & bus.I_dataB;
            ALU_XOR:    alu_s = bus.I_dataA ^ bus.I_dataB;
            ALU_SEXT8:  alu_s = {{24{bus.I_dataA[7]}}, bus.I_dataA[7:0]};
            ALU_SEXT16: alu_s = {{16{bus.I_dataA[15]}}, bus.I_dataA[15:0]};
            ALU_SHL:    alu_s = bus.I_dataA << bus.I_dataB[4:0];
            ALU_SHR:    alu_s = bus.I_dataA >> bus.I_dataB[4:0];
            ALU_SAR:    alu_s = 32'($signed(bus.I_dataA) >>> bus.I_dataB[4:0]);
            ALU_MUL:    alu_s = mul_done_s ? mul_product_s : 32'd0;
            default:    alu_s = 32'd0;
        endcase
    end

    assign link_pc_s = bus.I_PC + 14'd1;
    assign result_s  = (bus.I_selWe == WE_LINK) ? {16'd0, link_pc_s, 2'b00} : alu_s;

    // Result bundle and flag next-state; a stall loads a bubble and holds the flags.
    always_comb begin
        result_d = 32'd0;
        we_d     = 1'b0;
        regd_d   = 5'd0;
        selwe_d  = 2'd0;
        selmem_d = 4'd0;
        flags_d  = flags_q;
        if (stall_s) begin
            flags_d = flags_q;
        end else begin
            result_d = result_s;
            we_d     = bus.I_we;
            regd_d   = bus.I_regD;
            selwe_d  = bus.I_selWe;
            selmem_d = bus.I_selMem;
            if (bus.I_we && (bus.I_selWe == WE_ALU) && !bus.I_isBranch) begin
                flags_d[2] = alu_s[31];
                flags_d[1] = (alu_s == 32'd0);
                if (bus.I_aluop == ALU_ADD) begin
                    flags_d[0] = sum_s[32];
                end else begin
                    flags_d[0] = flags_q[0];
                end
            end else begin
                flags_d = flags_q;
            end
        end
    end

    // Output and flag registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            result_q <= 32'd0;
            we_q     <= 1'b0;
            regd_q   <= 5'd0;
            selwe_q  <= 2'd0;
            selmem_q <= 4'd0;
            flags_q  <= 3'd0;
        end else begin
            result_q <= result_d;
            we_q     <= we_d;
            regd_q   <= regd_d;
            selwe_q  <= selwe_d;
            selmem_q <= selmem_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.O_result       = result_q;
    assign bus.O_we           = we_q;
    assign bus.O_regD         = regd_q;
    assign bus.O_selWe        = selwe_q;
    assign bus.O_selMem       = selmem_q;
    assign bus.O_flags        = flags_q;
    assign bus.O_branchTaken  = I_rst_n & bus.I_isBranch & branch_cond(bus.I_branchOp, flags_q);
    assign bus.O_branchTarget = bus.I_branchAddress;
    assign bus.O_flush        = bus.O_branchTaken;
    assign bus.O_stall        = stall_s;
endmodule

// File: tb/tb_ceespu_execute.sv
// Directed self-checking bench for ceespu_execute (default iterative multiplier, 8-bit steps).
module tb_ceespu_execute;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ceespu_execute_if bus();

    ceespu_execute #(.MUL_STEP_BITS(8)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] cin, input logic we, input logic [4:0] rd,
                       input logic [1:0] swe, input logic br, input logic [2:0] bop,
                       input logic [13:0] badr, input logic [13:0] pc);
        bus.I_aluop         = op;
        bus.I_dataA         = a;
        bus.I_dataB         = b;
        bus.I_selCin        = cin;
        bus.I_we            = we;
        bus.I_regD          = rd;
        bus.I_selWe         = swe;
        bus.I_selMem        = rd[3:0];
        bus.I_isBranch      = br;
        bus.I_branchOp      = bop;
        bus.I_branchAddress = badr;
        bus.I_PC            = pc;
        #1;
    endtask

    task automatic bubble();
        drv(4'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
    endtask

    initial begin
        // reset: an always-branch on the input must not flush while in reset
        drv(4'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 3'd0, 14'd0, 14'd0);
        repeat (2) step();
        chk("rst_result", bus.O_result, 32'd0);
        chk("rst_we", {31'd0, bus.O_we}, 32'd0);
        chk("rst_flags", {29'd0, bus.O_flags}, 32'd0);
        chk("rst_flush", {31'd0, bus.O_flush}, 32'd0);
        chk("rst_stall", {31'd0, bus.O_stall}, 32'd0);
        rst_n = 1'b1;

        // ADD overflow to zero: Z=1 C=1
        drv(4'd0, 32'hFFFF_FFFF, 32'd1, 2'd0, 1'b1, 5'd1, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("add_res", bus.O_result, 32'd0);
        chk("add_we", {31'd0, bus.O_we}, 32'd1);
        chk("add_regd", {27'd0, bus.O_regD}, 32'd1);
        chk("add_flags", {29'd0, bus.O_flags}, 32'd3);

        // SUB 7-5 with A pre-inverted, cin=1
        drv(4'd0, ~32'd5, 32'd7, 2'd3, 1'b1, 5'd2, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("sub_res", bus.O_result, 32'd2);
        chk("sub_flags", {29'd0, bus.O_flags}, 32'd1);

        // ADD with cin from C (=1): 1+1+1
        drv(4'd0, 32'd1, 32'd1, 2'd1, 1'b1, 5'd3, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("addc_res", bus.O_result, 32'd3);
        chk("addc_flags", {29'd0, bus.O_flags}, 32'd0);
        chk("addc_selmem", {28'd0, bus.O_selMem}, 32'd3);

        drv(4'd1, 32'hF0F0_0000, 32'h0000_0F0F, 2'd0, 1'b1, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("or_res", bus.O_result, 32'hF0F0_0F0F);
        chk("or_flags", {29'd0, bus.O_flags}, 32'd4);

        drv(4'd2, 32'h0FF0_1234, 32'h00FF_00F0, 2'd0, 1'b1, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("and_res", bus.O_result, 32'h00F0_0030);

        drv(4'd4, 32'h0000_0080, 32'd0, 2'd0, 1'b1, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("sext8_res", bus.O_result, 32'hFFFF_FF80);

        drv(4'd5, 32'h1234_8001, 32'd0, 2'd0, 1'b1, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("sext16_res", bus.O_result, 32'hFFFF_8001);

        // ADD setting C=1, then a SHL must keep C
        drv(4'd0, 32'hFFFF_FFFF, 32'd2, 2'd0, 1'b1, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("add2_flags", {29'd0, bus.O_flags}, 32'd1);
        drv(4'd6, 32'd1, 32'h0000_0024, 2'd0, 1'b1, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("shl_res", bus.O_result, 32'h0000_0010);
        chk("shl_flags", {29'd0, bus.O_flags}, 32'd1);

        drv(4'd7, 32'h8000_0000, 32'd31, 2'd0, 1'b1, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("shr_res", bus.O_result, 32'd1);

        drv(4'd8, 32'h8000_0000, 32'd4, 2'd0, 1'b1, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("sar_res", bus.O_result, 32'hF800_0000);
        chk("sar_flags", {29'd0, bus.O_flags}, 32'd5);

        // we=0: flags must hold
        drv(4'd3, 32'd9, 32'd9, 2'd0, 1'b0, 5'd4, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("nowe_flags", {29'd0, bus.O_flags}, 32'd5);
        chk("nowe_we", {31'd0, bus.O_we}, 32'd0);

        // MUL: 5 stall cycles with bubbles, result on the 6th
        drv(4'd9, 32'h0001_2345, 32'h0000_1000, 2'd0, 1'b1, 5'd5, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mul_stall%0d", i), {31'd0, bus.O_stall}, 32'd1);
            step();
            chk($sformatf("mul_bub_we%0d", i), {31'd0, bus.O_we}, 32'd0);
            chk($sformatf("mul_bub_res%0d", i), bus.O_result, 32'd0);
        end
        chk("mul_done_stall", {31'd0, bus.O_stall}, 32'd0);
        step();
        bubble();
        chk("mul_res", bus.O_result, 32'h1234_5000);
        chk("mul_we", {31'd0, bus.O_we}, 32'd1);
        chk("mul_regd", {27'd0, bus.O_regD}, 32'd5);
        chk("mul_flags", {29'd0, bus.O_flags}, 32'd1);
        chk("mul_after_stall", {31'd0, bus.O_stall}, 32'd0);

        // XOR A=B sets Z; next-cycle branch on Z is taken
        drv(4'd3, 32'h55, 32'h55, 2'd0, 1'b1, 5'd6, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        step();
        chk("xor_flags", {29'd0, bus.O_flags}, 32'd3);
        drv(4'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1, 3'd1, 14'h100, 14'd7);
        chk("bz_flush", {31'd0, bus.O_flush}, 32'd1);
        chk("bz_taken", {31'd0, bus.O_branchTaken}, 32'd1);
        chk("bz_target", {18'd0, bus.O_branchTarget}, 32'h100);
        bus.I_branchOp = 3'd2;
        #1;
        chk("bnz_flush", {31'd0, bus.O_flush}, 32'd0);
        step();

        // linked always-branch at PC 0x10
        drv(4'd0, 32'd0, 32'd0, 2'd0, 1'b1, 5'd19, 2'd3, 1'b1, 3'd0, 14'h20, 14'h10);
        chk("link_flush", {31'd0, bus.O_flush}, 32'd1);
        step();
        bubble();
        chk("link_res", bus.O_result, 32'h44);
        chk("link_we", {31'd0, bus.O_we}, 32'd1);
        chk("link_regd", {27'd0, bus.O_regD}, 32'd19);
        chk("link_selwe", {30'd0, bus.O_selWe}, 32'd3);
        chk("link_flags", {29'd0, bus.O_flags}, 32'd3);

        // reset in the third BUSY cycle aborts the multiply
        drv(4'd9, 32'd3, 32'd7, 2'd0, 1'b1, 5'd7, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        repeat (3) step();
        chk("pre_rst_stall", {31'd0, bus.O_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", {31'd0, bus.O_stall}, 32'd0);
        chk("abort_res", bus.O_result, 32'd0);
        chk("abort_flags", {29'd0, bus.O_flags}, 32'd0);
        chk("abort_we", {31'd0, bus.O_we}, 32'd0);
        step();
        rst_n = 1'b1;

        // fresh MUL exercising the top byte of B
        drv(4'd9, 32'h1234_5678, 32'h0100_0001, 2'd0, 1'b1, 5'd8, 2'd0, 1'b0, 3'd0, 14'd0, 14'd0);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("mul2_stall%0d", j), {31'd0, bus.O_stall}, 32'd1);
            step();
        end
        chk("mul2_done_stall", {31'd0, bus.O_stall}, 32'd0);
        step();
        bubble();
        chk("mul2_res", bus.O_result, 32'h8A34_5678);
        chk("mul2_we", {31'd0, bus.O_we}, 32'd1);
        chk("mul2_flags", {29'd0, bus.O_flags}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
